// File: rtl/boot_rom_arbiter.sv
// rtl/boot_rom_arbiter.sv - dbus/ibus arbiter for a shared single-port 1-cycle-latency memory
module boot_rom_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // data bus slave port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // instruction bus slave port (read only)
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  // memory macro port
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // A zero-wide counter is not legal, so strict-priority builds keep one idle bit.
  localparam int             SW         = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);
  localparam bit             GUARD_ON   = (MAX_D_STREAK != 0);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DBUS = 2'd1,
    OWN_IBUS = 2'd2
  } owner_e;

  logic [SW-1:0] streak;
  owner_e        owner;
  logic          wr_flag;
  logic          force_i;

  // ibus is pushed through once dbus has beaten it MAX_D_STREAK times in a row
  assign force_i = GUARD_ON && (streak == STREAK_MAX);

  // Single-winner grant: dbus first unless the starvation guard has tripped
  always_comb begin
    d_gnt = d_req && !(i_req && force_i);
    i_gnt = i_req && !d_gnt;
  end

  // Steer the winning bus onto the memory port; idle drives all zeros
  always_comb begin
    mem_req   = d_gnt | i_gnt;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_we    = 1'b0;
      mem_be    = 4'hF;
      mem_addr  = i_addr;
      mem_wdata = 32'h0;
    end
  end

  // Count consecutive dbus wins while ibus waits; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!i_req || i_gnt) begin
      streak <= '0;
    end else if (d_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + SW'(1);
    end
  end

  // Remember who owns the data coming back from the macro next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_NONE;
      wr_flag <= 1'b0;
    end else begin
      wr_flag <= mem_we;
      if (d_gnt) begin
        owner <= OWN_DBUS;
      end else if (i_gnt) begin
        owner <= OWN_IBUS;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // Writes still complete with rvalid but carry no data
  assign d_rvalid = (owner == OWN_DBUS);
  assign i_rvalid = (owner == OWN_IBUS);
  assign d_rdata  = (d_rvalid && !wr_flag) ? mem_rdata : 32'h0;
  assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;

endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
- Shares one single-port synchronous memory (boot ROM / scratch RAM macro) between the core's data bus and instruction bus.
- Default priority is data bus first, with a bounded-starvation guarantee for the instruction bus.
- Routes each registered read response back to the bus that owns it.
- Sits between the bus fabric slave ports and the memory macro; the macro has 1-cycle read latency.

Parameters:
- ADDR_W, 32, address width of both buses and the memory port.
- MAX_D_STREAK, 4, max consecutive dbus grants while ibus is waiting before ibus is forced through; 0 = strict dbus priority, no starvation guard.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- d_req  in  1  dbus request
- d_we  in  1  dbus write enable
- d_be  in  4  dbus byte enables
- d_addr  in  ADDR_W  dbus address
- d_wdata  in  32  dbus write data
- d_gnt  out  1  dbus grant (combinational)
- d_rvalid  out  1  dbus response valid
- d_rdata  out  32  dbus read data
- i_req  in  1  ibus request
- i_addr  in  ADDR_W  ibus address
- i_gnt  out  1  ibus grant (combinational)
- i_rvalid  out  1  ibus response valid
- i_rdata  out  32  ibus read data
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_req

Behaviour:
- Grant, combinational, at most one grant per cycle:
  - force_i = (MAX_D_STREAK != 0) && (streak == MAX_D_STREAK).
  - d_gnt = d_req && !(i_req && force_i).
  - i_gnt = i_req && !d_gnt.
- Memory drive:
  - mem_req = d_gnt | i_gnt.
  - On d_gnt: mem_addr/we/be/wdata come from d_*.
  - On i_gnt: mem_addr = i_addr, mem_we = 0, mem_be = 4'hF, mem_wdata = 0.
  - Idle: all memory outputs 0.
- Streak counter, width $clog2(MAX_D_STREAK+1), saturating:
  - Increments when d_gnt && i_req.
  - Clears when i_gnt, or when !i_req.
  - Holds otherwise; never exceeds MAX_D_STREAK.
- Response state, registered:
  - owner ∈ {NONE, DBUS, IBUS}, plus wr_flag.
  - Next cycle after a grant: owner = granted bus, wr_flag = mem_we; with no grant, owner = NONE.
  - d_rvalid = (owner == DBUS); i_rvalid = (owner == IBUS).
  - Latency from gnt to rvalid is exactly 1 cycle; back-to-back grants give back-to-back responses with no bubble.
  - Writes also return rvalid.
- Read data:
  - d_rdata = mem_rdata when owner == DBUS && !wr_flag, else 0.
  - i_rdata = mem_rdata when owner == IBUS, else 0.
- Reset (async, rst_n low):
  - owner = NONE, wr_flag = 0, streak = 0 immediately.
  - All rvalid/rdata = 0.
  - gnt and mem_* follow inputs combinationally but are ignored by the design during reset.
  - A response in flight at reset is dropped; no rvalid is issued after reset release.
- Boundary conditions:
  - Simultaneous d_req and i_req with streak < MAX: dbus wins.
  - Both requesting with streak == MAX: ibus wins and streak clears the same edge. The dbus request must be held by the master and is granted on the next cycle.
  - MAX_D_STREAK = 0: ibus is granted only when d_req is low.
  - Requests are not registered; a request dropped before grant is simply lost, with no side effects.

Test Plan:
- Reset, then d_req=1, d_addr=0x10, d_we=0 for 1 cycle, mem_rdata=0xDEADBEEF next cycle -> d_gnt=1 in cycle 0; d_rvalid=1, d_rdata=0xDEADBEEF in cycle 1; i_rvalid=0 throughout.
- d_req and i_req held high for 12 cycles, MAX_D_STREAK=4 -> grant pattern D,D,D,D,I repeating (10 D, 2 I total); every rvalid lands exactly 1 cycle after its gnt.
- Same stimulus with MAX_D_STREAK=0 -> 12 D grants, 0 I grants; ibus granted in the first cycle after d_req drops.
- dbus write d_be=4'b0011, d_wdata=0x1234ABCD -> mem_we=1, mem_be=4'b0011, mem_wdata=0x1234ABCD in the gnt cycle; next cycle d_rvalid=1, d_rdata=0.
- i_gnt issued, rst_n asserted before the next clock edge -> i_rvalid=0, owner=NONE; after release with no requests, no rvalid appears.
- Alternating single-cycle d_req and i_req with no overlap -> each granted immediately; streak stays 0; responses carry the correct per-cycle mem_rdata values (e.g. 0x1, 0x2, 0x3).
